part_syncram_dp: RTL and testbench

PART_SYNCRAM_DP -- requirements
Module: part_syncram_dp

---
 rtl/part_syncram_dp.sv | 160 ++++++++++++++++
 tb/tb_part_syncram_dp.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/part_syncram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : part_syncram_dp
//  Purpose  : Single-clock RAM, 2**AW x DW. Port A reads and writes with
//             per-byte enables; port B is read-only. Reads are registered
//             (one cycle of latency). Reset can start a hardware zero-fill
//             of the whole array, one word per cycle.
//  Ports    : clk_a      - clock, all logic on the rising edge
//             reset      - synchronous, active-high reset
//             address_a  - port A address     data_a  - port A write data
//             byteen_a   - port A byte enables (bit i -> data[8i+7:8i])
//             rden_a     - port A read strobe wren_a  - port A write strobe
//             q_a        - port A registered read data
//             address_b  - port B address     rden_b  - port B read strobe
//             q_b        - port B registered read data
//             busy       - high while the zero-fill runs
//  Revision : 1.0 - initial release
// ============================================================================
module part_syncram_dp #(
    parameter int AW             = 10,
    parameter int DW             = 32,
    parameter int RDW_NEW        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk_a,
    input  logic            reset,
    input  logic [AW-1:0]   address_a,
    input  logic [DW-1:0]   data_a,
    input  logic [DW/8-1:0] byteen_a,
    input  logic            rden_a,
    input  logic            wren_a,
    output logic [DW-1:0]   q_a,
    input  logic [AW-1:0]   address_b,
    input  logic            rden_b,
    output logic [DW-1:0]   q_b,
    output logic            busy
);

    localparam int          c_NB    = DW / 8;
    localparam int          c_DEPTH = 2 ** AW;
    // Last word address, held in the (AW+1)-bit pointer width.
    localparam logic [AW:0] c_LAST  = {1'b0, {AW{1'b1}}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW:0]   r_ptr;
    logic [DW-1:0] r_mem [c_DEPTH];
    logic [DW-1:0] r_q_a;
    logic [DW-1:0] r_q_b;

    logic          w_wr_en;
    logic [DW-1:0] w_old_a;
    logic [DW-1:0] w_old_b;
    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;

    assign busy    = (r_state == ST_CLEAR);
    // User accesses are dropped both during the fill and in the reset cycle.
    assign w_wr_en = wren_a & ~busy & ~reset;
    assign w_old_a = r_mem[address_a];
    assign w_old_b = r_mem[address_b];
    assign q_a     = r_q_a;
    assign q_b     = r_q_b;

    // ------------------------------------------------------------------------
    // Zero-fill sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_a) begin
        if (reset) begin
            r_ptr <= '0;
            if (CLEAR_ON_RESET != 0) begin
                r_state <= ST_CLEAR;
            end else begin
                r_state <= ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == c_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ptr <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Array: fill writes take priority; user writes are byte-masked
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_a) begin
        if ((r_state == ST_CLEAR) && !reset) begin
            r_mem[r_ptr[AW-1:0]] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < c_NB; i++) begin
                if (byteen_a[i]) begin
                    r_mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read-during-write selection
    // ------------------------------------------------------------------------
    if (RDW_NEW != 0) begin : g_rdw_new
        logic          w_hit_b;
        logic [DW-1:0] w_new_a;
        logic [DW-1:0] w_new_b;

        assign w_hit_b = w_wr_en && (address_b == address_a);

        // Forward the written bytes over the stored word so a colliding read
        // sees the post-write, byte-merged value.
        always_comb begin
            w_new_a = w_old_a;
            w_new_b = w_old_b;
            for (int i = 0; i < c_NB; i++) begin
                if (w_wr_en && byteen_a[i]) begin
                    w_new_a[8*i +: 8] = data_a[8*i +: 8];
                end
                if (w_hit_b && byteen_a[i]) begin
                    w_new_b[8*i +: 8] = data_a[8*i +: 8];
                end
            end
        end

        assign w_rd_a = w_new_a;
        assign w_rd_b = w_new_b;
    end else begin : g_rdw_old
        assign w_rd_a = w_old_a;
        assign w_rd_b = w_old_b;
    end

    // ------------------------------------------------------------------------
    // Registered read ports: zero during reset and fill, hold when idle
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_a) begin
        if (reset || busy) begin
            r_q_a <= '0;
            r_q_b <= '0;
        end else begin
            if (rden_a) begin
                r_q_a <= w_rd_a;
            end
            if (rden_b) begin
                r_q_b <= w_rd_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_part_syncram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_part_syncram_dp
//  Purpose  : Self-checking bench for part_syncram_dp. Two 1024x32 instances
//             (old-data and new-data read-during-write) share one stimulus;
//             a 16x16 instance without clear-on-reset has its own.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_part_syncram_dp;

    logic clk;

    // Shared stimulus for the two AW=10 / DW=32 instances
    logic        reset;
    logic [9:0]  address_a, address_b;
    logic [31:0] data_a;
    logic [3:0]  byteen_a;
    logic        rden_a, wren_a, rden_b;
    logic [31:0] q_a_o, q_b_o, q_a_n, q_b_n;
    logic        busy_o, busy_n;

    // AW=4 / DW=16 / CLEAR_ON_RESET=0 instance
    logic        c_reset;
    logic [3:0]  c_address_a, c_address_b;
    logic [15:0] c_data_a;
    logic [1:0]  c_byteen_a;
    logic        c_rden_a, c_wren_a, c_rden_b;
    logic [15:0] c_q_a, c_q_b;
    logic        c_busy;
    logic        c_track;
    logic        c_busy_seen;

    int n_assert;
    int n_fail;

    typedef struct {
        int          port;
        logic [31:0] exp;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    part_syncram_dp #(.AW(10), .DW(32), .RDW_NEW(0), .CLEAR_ON_RESET(1)) u_old (
        .clk_a(clk), .reset(reset),
        .address_a(address_a), .data_a(data_a), .byteen_a(byteen_a),
        .rden_a(rden_a), .wren_a(wren_a), .q_a(q_a_o),
        .address_b(address_b), .rden_b(rden_b), .q_b(q_b_o),
        .busy(busy_o)
    );

    part_syncram_dp #(.AW(10), .DW(32), .RDW_NEW(1), .CLEAR_ON_RESET(1)) u_new (
        .clk_a(clk), .reset(reset),
        .address_a(address_a), .data_a(data_a), .byteen_a(byteen_a),
        .rden_a(rden_a), .wren_a(wren_a), .q_a(q_a_n),
        .address_b(address_b), .rden_b(rden_b), .q_b(q_b_n),
        .busy(busy_n)
    );

    part_syncram_dp #(.AW(4), .DW(16), .RDW_NEW(0), .CLEAR_ON_RESET(0)) u_nclr (
        .clk_a(clk), .reset(c_reset),
        .address_a(c_address_a), .data_a(c_data_a), .byteen_a(c_byteen_a),
        .rden_a(c_rden_a), .wren_a(c_wren_a), .q_a(c_q_a),
        .address_b(c_address_b), .rden_b(c_rden_b), .q_b(c_q_b),
        .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port ids: 0 old.q_a, 1 old.q_b, 2 new.q_a, 3 new.q_b, 4 nclr.q_a, 5 nclr.q_b
    function automatic logic [31:0] observe(input int port);
        case (port)
            0:       return q_a_o;
            1:       return q_b_o;
            2:       return q_a_n;
            3:       return q_b_n;
            4:       return {16'h0, c_q_a};
            5:       return {16'h0, c_q_b};
            default: return 'x;
        endcase
    endfunction

    task automatic push(input int port, input logic [31:0] exp, input string tag);
        sb_t e;
        e.port = port;
        e.exp  = exp;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    // Same expectation on both shared-stimulus instances
    task automatic push_ab(input logic [31:0] ea, input logic [31:0] eb, input string tag);
        push(0, ea, tag);
        push(1, eb, tag);
        push(2, ea, tag);
        push(3, eb, tag);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then retire every expectation queued for that edge.
    task automatic cyc();
        sb_t e;
        @(posedge clk);
        #1;
        if (c_track && (c_busy !== 1'b0)) c_busy_seen = 1'b1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_assert++;
            assert (observe(e.port) === e.exp)
            else begin
                n_fail++;
                $error("FAIL %s port%0d observed=%h expected=%h",
                       e.tag, e.port, observe(e.port), e.exp);
            end
        end
    endtask

    task automatic idle();
        rden_a   = 1'b0;
        wren_a   = 1'b0;
        rden_b   = 1'b0;
        byteen_a = '0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        wren_a    = 1'b1;
        address_a = a;
        data_a    = d;
        byteen_a  = be;
        cyc();
        idle();
    endtask

    // Count the samples for which busy stays high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while ((busy_o === 1'b1) && (n < 2000)) begin
            n++;
            cyc();
        end
    endtask

    initial begin
        int n;
        n_assert    = 0;
        n_fail      = 0;
        c_track     = 1'b0;
        c_busy_seen = 1'b0;
        address_a   = '0;
        address_b   = '0;
        data_a      = '0;
        idle();
        c_reset     = 1'b0;
        c_address_a = '0;
        c_address_b = '0;
        c_data_a    = '0;
        c_byteen_a  = '0;
        c_rden_a    = 1'b0;
        c_wren_a    = 1'b0;
        c_rden_b    = 1'b0;

        // ---- reset state and full-array fill -------------------------------
        reset = 1'b1;
        push_ab(32'h0, 32'h0, "reset_q");
        cyc();
        chk("reset_busy", {31'b0, busy_o}, 32'h1);
        reset = 1'b0;

        // Accesses during the fill are dropped and q stays zero.
        n = 0;
        while ((busy_o === 1'b1) && (n < 2000)) begin
            if (n == 0) begin
                wren_a    = 1'b1;
                rden_a    = 1'b1;
                rden_b    = 1'b1;
                address_a = 10'd5;
                address_b = 10'd5;
                data_a    = 32'hFFFF_FFFF;
                byteen_a  = 4'hF;
            end
            if (n < 2) push_ab(32'h0, 32'h0, "busy_q");
            if (n == 2) idle();
            n++;
            cyc();
        end
        chk("fill_len", n, 32'd1024);
        chk("fill_done_new", {31'b0, busy_n}, 32'h0);

        rden_a    = 1'b1;
        address_a = 10'h3FF;
        rden_b    = 1'b1;
        address_b = 10'd5;
        push_ab(32'h0, 32'h0, "post_fill");
        cyc();
        idle();

        // ---- byte-enable merge ---------------------------------------------
        wr(10'd5, 32'hDEAD_BEEF, 4'hF);
        wr(10'd5, 32'h0000_1100, 4'b0010);
        rden_a    = 1'b1;
        address_a = 10'd5;
        rden_b    = 1'b1;
        address_b = 10'd5;
        push_ab(32'hDEAD_11EF, 32'hDEAD_11EF, "byte_merge");
        cyc();
        idle();

        // Write with no byte enables changes nothing.
        wr(10'd5, 32'h0000_0000, 4'h0);

        // Write elsewhere while port B reads word 5; q_a holds.
        wren_a    = 1'b1;
        address_a = 10'd9;
        data_a    = 32'hCAFE_F00D;
        byteen_a  = 4'hF;
        rden_b    = 1'b1;
        address_b = 10'd5;
        push_ab(32'hDEAD_11EF, 32'hDEAD_11EF, "other_addr");
        cyc();
        idle();

        rden_a    = 1'b1;
        address_a = 10'd5;
        rden_b    = 1'b1;
        address_b = 10'd9;
        push_ab(32'hDEAD_11EF, 32'hCAFE_F00D, "be_zero");
        cyc();
        idle();

        // ---- same-address read during write --------------------------------
        wr(10'd7, 32'h1111_1111, 4'hF);
        wren_a    = 1'b1;
        address_a = 10'd7;
        data_a    = 32'h2222_2222;
        byteen_a  = 4'hF;
        rden_a    = 1'b1;
        rden_b    = 1'b1;
        address_b = 10'd7;
        push(0, 32'h1111_1111, "rdw_full");
        push(1, 32'h1111_1111, "rdw_full");
        push(2, 32'h2222_2222, "rdw_full");
        push(3, 32'h2222_2222, "rdw_full");
        cyc();

        data_a   = 32'h3333_33AA;
        byteen_a = 4'b0001;
        push(0, 32'h2222_2222, "rdw_part");
        push(1, 32'h2222_2222, "rdw_part");
        push(2, 32'h2222_22AA, "rdw_part");
        push(3, 32'h2222_22AA, "rdw_part");
        cyc();
        idle();

        rden_a = 1'b1;
        rden_b = 1'b1;
        push_ab(32'h2222_22AA, 32'h2222_22AA, "rdw_after");
        cyc();
        idle();

        // ---- q_a holds while rden_a is low ---------------------------------
        wr(10'd3, 32'hA5A5_A5A5, 4'hF);
        rden_a    = 1'b1;
        address_a = 10'd3;
        push(0, 32'hA5A5_A5A5, "hold_rd");
        push(2, 32'hA5A5_A5A5, "hold_rd");
        cyc();
        idle();
        address_a = 10'd9;
        push(0, 32'hA5A5_A5A5, "hold_1");
        push(2, 32'hA5A5_A5A5, "hold_1");
        cyc();
        wren_a    = 1'b1;
        address_a = 10'd3;
        data_a    = 32'h0;
        byteen_a  = 4'hF;
        push(0, 32'hA5A5_A5A5, "hold_wr");
        push(2, 32'hA5A5_A5A5, "hold_wr");
        cyc();
        idle();
        address_a = 10'h3FF;
        push(0, 32'hA5A5_A5A5, "hold_3");
        push(2, 32'hA5A5_A5A5, "hold_3");
        cyc();

        // ---- reset in the middle of a fill ---------------------------------
        wr(10'd0, 32'h5555_5555, 4'hF);
        reset     = 1'b1;
        rden_a    = 1'b1;
        address_a = 10'd0;
        push(0, 32'h0, "rst_cycle_rd");
        push(2, 32'h0, "rst_cycle_rd");
        cyc();
        reset = 1'b0;
        idle();
        repeat (500) cyc();
        chk("mid_fill_busy", {31'b0, busy_o}, 32'h1);
        reset = 1'b1;
        cyc();
        chk("restart_busy", {31'b0, busy_o}, 32'h1);
        reset = 1'b0;
        count_busy(n);
        chk("refill_len", n, 32'd1024);
        rden_a    = 1'b1;
        address_a = 10'd0;
        rden_b    = 1'b1;
        address_b = 10'd9;
        push_ab(32'h0, 32'h0, "refill_zero");
        cyc();
        idle();

        // ---- no clear on reset: contents survive ---------------------------
        c_reset = 1'b1;
        push(4, 32'h0, "nclr_reset_q");
        push(5, 32'h0, "nclr_reset_q");
        cyc();
        chk("nclr_reset_busy", {31'b0, c_busy}, 32'h0);
        c_track = 1'b1;
        c_reset = 1'b0;

        c_wren_a    = 1'b1;
        c_address_a = 4'hA;
        c_data_a    = 16'hBEEF;
        c_byteen_a  = 2'b11;
        cyc();
        c_address_a = 4'hB;
        c_data_a    = 16'h1234;
        cyc();
        c_data_a    = 16'hAB00;
        c_byteen_a  = 2'b10;
        cyc();

        // Reset with a write and a read in the same cycle: both dropped.
        c_reset     = 1'b1;
        c_address_a = 4'hA;
        c_data_a    = 16'h0000;
        c_byteen_a  = 2'b11;
        c_rden_a    = 1'b1;
        push(4, 32'h0, "nclr_rst_rd");
        cyc();
        c_reset     = 1'b0;
        c_wren_a    = 1'b0;
        c_rden_b    = 1'b1;
        c_address_b = 4'hB;
        push(4, 32'h0000_BEEF, "nclr_keep_a");
        push(5, 32'h0000_AB34, "nclr_keep_b");
        cyc();
        c_rden_a = 1'b0;
        c_rden_b = 1'b0;
        cyc();
        chk("nclr_busy_never", {31'b0, c_busy_seen}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
